// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM state type and access-legality helper for load_store_unit
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, WAIT, FAULT} lsu_state_t;

    // Unsigned loads have no store counterpart, so they are only legal for loads.
    function automatic logic lsu_legal(input logic ld, input logic [2:0] f3, input logic [1:0] off);
        logic b, h, w;
        b = f3 == F3_LB || (ld && f3 == F3_LBU);
        h = f3 == F3_LH || (ld && f3 == F3_LHU);
        w = f3 == F3_LW;
        return b || (h && !off[0]) || (w && off == 2'b00);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/halfword lane of read data and sign- or zero-extends it
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  f3,
    output logic [31:0] data
);

    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        sh   = rdata >> {off, 3'b000};
        b    = sh[7:0];
        h    = off[1] ? rdata[31:16] : rdata[15:0];
        data = f3 == F3_LB  ? {{24{b[7]}}, b}  :
               f3 == F3_LH  ? {{16{h[15]}}, h} :
               f3 == F3_LBU ? {24'h0, b}       :
               f3 == F3_LHU ? {16'h0, h}       : rdata;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: req/ack data-memory access stage with store lane steering and load alignment; LSU_TIMEOUT_EN adds an ack timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    lsu_state_t  state_q, state_d;
    logic        acc, legal, ack, tmo;
    logic        req_q, we_q, done_q, berr_q, ld_q;
    logic [31:2] addr_q;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d, load_q, aligned;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    assign acc   = state_q == IDLE && ex_valid && (ex_load || ex_store);
    assign legal = lsu_legal(ex_load, funct3, addr[1:0]);
    assign ack   = state_q == WAIT && dmem_ack;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk)
        cnt_q <= (rst || state_q != WAIT) ? '0 : cnt_q + 1'b1;
    // An ack in the last counted cycle takes priority over the timeout.
    assign tmo = state_q == WAIT && !dmem_ack && cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
    assign tmo = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk)
        state_q <= rst ? IDLE : state_d;

    always_comb
        state_d = state_q == IDLE ? (acc ? (legal ? WAIT : FAULT) : IDLE) :
                  state_q == WAIT ? ((ack || tmo) ? IDLE : WAIT) : IDLE;

    always_comb begin
        be_d    = ex_load             ? 4'b1111                      :
                  funct3 == F3_SB     ? 4'b0001 << addr[1:0]         :
                  funct3 == F3_SH     ? 4'b0011 << {addr[1], 1'b0}   : 4'b1111;
        wdata_d = funct3 == F3_SB ? {4{wdata[7:0]}}  :
                  funct3 == F3_SH ? {2{wdata[15:0]}} : wdata;
    end

    lsu_load_align u_align (
        .rdata (dmem_rdata),
        .off   (off_q),
        .f3    (f3_q),
        .data  (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            ld_q    <= 1'b0;
            done_q  <= 1'b0;
            berr_q  <= 1'b0;
            load_q  <= '0;
        end else begin
            done_q <= ack || tmo;
            berr_q <= tmo;
            if (acc && legal) begin
                req_q   <= 1'b1;
                we_q    <= !ex_load;
                addr_q  <= addr[31:2];
                be_q    <= be_d;
                wdata_q <= wdata_d;
                f3_q    <= funct3;
                off_q   <= addr[1:0];
                ld_q    <= ex_load;
            end else if (ack || tmo) begin
                req_q <= 1'b0;
            end
            if (ack && ld_q)
                load_q <= aligned;
        end
    end

    always_comb begin
        busy       = state_q != IDLE;
        fault      = state_q == FAULT;
        done       = done_q || fault;
        bus_err    = berr_q;
        load_data  = load_q;
        dmem_req   = req_q;
        dmem_we    = we_q;
        dmem_addr  = {addr_q, 2'b00};
        dmem_wdata = wdata_q;
        dmem_be    = be_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        busy, done, fault, bus_err;
    logic [31:0] load_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    int          checks = 0, failures = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_load    (ex_load),
        .ex_store   (ex_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .fault      (fault),
        .bus_err    (bus_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge; returns in cycle 1 after acceptance.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; funct3 = f3; addr = a; wdata = wd;
        step();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    endtask

    initial begin
        int n;
        step();
        step();
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_req", {31'b0, dmem_req}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_berr", {31'b0, bus_err}, 32'd0);
        check("rst_ldata", load_data, 32'd0);
        check("rst_be", {28'b0, dmem_be}, 32'd0);

        // LB sign-extend, zero wait states
        issue(1, 0, 3'b000, 32'h103, 32'h0);
        check("lb_req", {31'b0, dmem_req}, 32'd1);
        check("lb_addr", dmem_addr, 32'h100);
        check("lb_be", {28'b0, dmem_be}, 32'hF);
        check("lb_we", {31'b0, dmem_we}, 32'd0);
        check("lb_done_c1", {31'b0, done}, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_1234;
        step();
        dmem_ack = 1'b0;
        check("lb_done_c2", {31'b0, done}, 32'd1);
        check("lb_data", load_data, 32'hFFFF_FF80);
        check("lb_req_off", {31'b0, dmem_req}, 32'd0);
        check("lb_busy_off", {31'b0, busy}, 32'd0);
        step();
        check("lb_done_pulse", {31'b0, done}, 32'd0);

        // LHU with 3 wait states
        issue(1, 0, 3'b101, 32'h202, 32'h0);
        n = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            n++;
            check("lhu_addr_hold", dmem_addr, 32'h200);
            if (n == 4) begin
                dmem_ack = 1'b1; dmem_rdata = 32'hBEEF_0000;
            end
            step();
            dmem_ack = 1'b0;
        end
        check("lhu_busy_cycles", n, 32'd4);
        check("lhu_done", {31'b0, done}, 32'd1);
        check("lhu_data", load_data, 32'h0000_BEEF);

        // SB lane placement; store leaves load_data alone
        issue(0, 1, 3'b000, 32'h11, 32'h0000_00AB);
        check("sb_be", {28'b0, dmem_be}, 32'b0010);
        check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        check("sb_addr", dmem_addr, 32'h10);
        check("sb_we", {31'b0, dmem_we}, 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
        step();
        dmem_ack = 1'b0;
        check("sb_done", {31'b0, done}, 32'd1);
        check("sb_ldata_kept", load_data, 32'h0000_BEEF);

        // Misaligned word load
        issue(1, 0, 3'b010, 32'h6, 32'h0);
        check("lw_mis_req", {31'b0, dmem_req}, 32'd0);
        check("lw_mis_fault", {31'b0, fault}, 32'd1);
        check("lw_mis_done", {31'b0, done}, 32'd1);
        step();
        check("lw_mis_fault_pulse", {31'b0, fault}, 32'd0);
        check("lw_mis_done_pulse", {31'b0, done}, 32'd0);
        check("lw_mis_ldata", load_data, 32'h0000_BEEF);

        // Unsupported funct3
        issue(1, 0, 3'b011, 32'h0, 32'h0);
        check("bad_f3_fault", {31'b0, fault}, 32'd1);
        check("bad_f3_req", {31'b0, dmem_req}, 32'd0);
        step();

        // SH upper half, then back-to-back LH accepted in the done cycle
        issue(0, 1, 3'b001, 32'h2, 32'h5555_1234);
        check("sh_be", {28'b0, dmem_be}, 32'b1100);
        check("sh_wdata", dmem_wdata, 32'h1234_1234);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("sh_done", {31'b0, done}, 32'd1);
        issue(1, 0, 3'b001, 32'h20, 32'h0);
        check("b2b_req", {31'b0, dmem_req}, 32'd1);
        check("b2b_we", {31'b0, dmem_we}, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'h0000_8001;
        step();
        dmem_ack = 1'b0;
        check("lh_data", load_data, 32'hFFFF_8001);

        // Load and store both set: load wins
        issue(1, 1, 3'b000, 32'h1, 32'hFFFF_FFFF);
        check("both_we", {31'b0, dmem_we}, 32'd0);
        check("both_be", {28'b0, dmem_be}, 32'hF);
        dmem_ack = 1'b1; dmem_rdata = 32'h0000_7F00;
        step();
        dmem_ack = 1'b0;
        check("both_data", load_data, 32'h0000_007F);

        // Reset mid-WAIT, then a late ack
        issue(1, 0, 3'b010, 32'h40, 32'h0);
        check("rw_req", {31'b0, dmem_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rw_req_off", {31'b0, dmem_req}, 32'd0);
        check("rw_busy_off", {31'b0, busy}, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_ack = 1'b0;
        check("rw_late_ack_done", {31'b0, done}, 32'd0);
        check("rw_ldata", load_data, 32'd0);

`ifdef LSU_TIMEOUT_EN
        issue(1, 0, 3'b010, 32'h80, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("tmo_waiting", {31'b0, busy}, 32'd1);
            step();
        end
        check("tmo_berr", {31'b0, bus_err}, 32'd1);
        check("tmo_done", {31'b0, done}, 32'd1);
        check("tmo_req_off", {31'b0, dmem_req}, 32'd0);
        check("tmo_idle", {31'b0, busy}, 32'd0);
        check("tmo_ldata", load_data, 32'd0);
        step();
        check("tmo_berr_pulse", {31'b0, bus_err}, 32'd0);
`else
        issue(1, 0, 3'b010, 32'h80, 32'h0);
        for (int i = 0; i < 10; i++) begin
            check("nt_berr", {31'b0, bus_err}, 32'd0);
            step();
        end
        check("nt_still_busy", {31'b0, busy}, 32'd1);
        check("nt_req_held", {31'b0, dmem_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RISC-V core: accepts one load or store per request from the execute stage and runs a req/ack transaction on the data-memory port. Generates byte enables for stores and aligns and extends data for loads. Flags misaligned or unsupported accesses. `load_data` feeds the memory-data input (`sel = 2'b01`) of the writeback 4:1 mux; `busy` stalls the upstream pipeline while a transaction is outstanding.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum cycles to wait for `dmem_ack`. Used only with `LSU_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: memory operation request.
- `ex_load` in 1: request is a load.
- `ex_store` in 1: request is a store.
- `funct3` in 3: access size and signedness, RV32I encoding.
- `addr` in 32: byte address.
- `wdata` in 32: store data, taken from the low bits.
- `busy` out 1: a transaction is outstanding; the upstream pipeline holds its request.
- `done` out 1: one-cycle pulse when an operation completes (success or fault).
- `load_data` out 32: aligned, extended load result; holds its value between loads.
- `fault` out 1: one-cycle pulse, coincident with `done`, for a misaligned or unsupported access.
- `bus_err` out 1: one-cycle pulse on ack timeout. Constant 0 without `LSU_TIMEOUT_EN`.
- `dmem_req`, `dmem_we` out 1: bus request and write strobe.
- `dmem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_wdata` out 32: store data, lane-replicated.
- `dmem_be` out 4: byte enables.
- `dmem_ack` in 1: transaction complete.
- `dmem_rdata` in 32: read data, valid in the ack cycle.

## Operation
- States: `IDLE`, `WAIT`, `FAULT`.
- **Accepting a request:** in `IDLE`, `ex_valid` with `ex_load|ex_store` is accepted. If both `ex_load` and `ex_store` are set, the load takes precedence.
- **Legality:**
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other `funct3`, a halfword access with `addr[0]=1`, or a word access with `addr[1:0]≠0` goes to `FAULT`. No bus cycle is issued.
- **Legal access:** go to `WAIT`. Register `dmem_req=1`, `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata`.
- **Store byte enables and data:**
  - SB: `be = 4'b0001 << addr[1:0]`, data byte replicated ×4.
  - SH: `be = 4'b0011 << {addr[1],1'b0}`, halfword replicated ×2.
  - SW: `be = 4'b1111`.
- **Load enables:** `dmem_be` is 4'b1111.
- **`WAIT`:** hold all `dmem_*` outputs stable until `dmem_ack`. At the ack edge:
  - Deassert `dmem_req`.
  - Pulse `done`.
  - For loads, register `load_data`: select the lane by `addr[1:0]`, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
  - Return to `IDLE`.
- **`FAULT`:** one cycle with `done=1` and `fault=1`, then `IDLE`. `load_data` is unchanged.
- **Stores** never change `load_data`.
- **Ignored inputs:**
  - `ex_valid` outside `IDLE` is ignored; upstream holds the request under `busy`.
  - `dmem_ack` outside `WAIT` is ignored.
- `busy = (state ≠ IDLE)`.

## Timing
- **Reset values:** all outputs 0, state `IDLE`.
- **Reset mid-transaction:** abandons it. `dmem_req` is 0 from the reset edge; a late ack is ignored.
- **Zero-wait memory:** accept at edge 0; `dmem_req` high in cycle 1 with ack in the same cycle; `done` and `load_data` valid in cycle 2. Minimum latency is 2 cycles.
- **Wait states:** N wait states give latency 2+N.
- **Fault latency:** accept at edge 0, `done`/`fault` in cycle 1.
- **Back-to-back requests:** a new request can be accepted in the same cycle that `done` is high, since the state is `IDLE` then. Throughput is one op per 2 cycles.

## Configuration
- Macro `LSU_TIMEOUT_EN` defined:
  - A cycle counter runs in `WAIT`.
  - If `TIMEOUT_CYCLES` cycles pass without ack: drop `dmem_req`, pulse `done` and `bus_err`, return to `IDLE`, and leave `load_data` unchanged.
  - An ack arriving in the final counted cycle wins over the timeout.
- Macro not defined: no counter, `WAIT` lasts indefinitely, and `bus_err` is tied to 0.

## Structure
- Package `lsu_pkg`:
  - `funct3` localparams (`F3_LB` … `F3_LHU`, `F3_SB`/`F3_SH`/`F3_SW`).
  - State enum `lsu_state_t`.
- Sub-module `lsu_load_align`: combinational. Takes `dmem_rdata`, `addr[1:0]` and `funct3`, and produces the extended 32-bit result.

## Test plan
- **LB sign-extend:** LB `addr=0x103`, rdata `0x80FF_1234`, ack in req cycle → `load_data = 0xFFFF_FF80`, `done` in cycle 2.
- **LHU wait states:** LHU `addr=0x202`, rdata `0xBEEF_0000`, ack after 3 wait states → `load_data = 0x0000_BEEF`, `busy` high 4 cycles.
- **SB lane placement:** SB `addr=0x11`, wdata `0x0000_00AB` → `dmem_be = 4'b0010`, `dmem_wdata = 0xABAB_ABAB`, `dmem_addr = 0x10`, `dmem_we = 1`.
- **Misaligned word:** LW `addr=0x6` → no `dmem_req`; `fault` and `done` pulse in cycle 1; `load_data` unchanged.
- **Reset mid-WAIT:** `rst` asserted while in `WAIT` → `dmem_req = 0` next cycle; a following ack produces no `done`.
- **Timeout (`LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`):** no ack → `bus_err` and `done` pulse after 4 `WAIT` cycles, then `IDLE`.
